// File: rtl/wb_port_arbiter_if.sv
// Register-file write port arbiter bus: write stage, multi-cycle unit,
// and the registered register-file write port.
interface wb_port_arbiter_if;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    modport slave (
        input  pipe_valid, pipe_reg, pipe_data,
        input  mc_valid, mc_reg, mc_data,
        output mc_ready, stall,
        output rf_we, rf_addr, rf_wdata
    );

    modport master (
        output pipe_valid, pipe_reg, pipe_data,
        output mc_valid, mc_reg, mc_data,
        input  mc_ready, stall,
        input  rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the write stage and an
// in-order buffer of multi-cycle results, with starvation and WAW squash.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               clr,
    wb_port_arbiter_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] dead_q, dead_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic full, nonempty, enq;
    logic grant_mc, grant_pipe;
    logic [4:0]  head_reg;
    logic [31:0] head_data;
    logic        head_dead;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign nonempty  = (count_q != '0);
    assign head_reg  = reg_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_dead = dead_q[rd_ptr_q];

    // Buffer wins when it has work and the pipe is idle, it is full,
    // or it has been passed over too many times in a row.
    assign grant_mc   = nonempty &
                        (!bus.pipe_valid | full |
                         (starve_q == SW'(STARVE_MAX)));
    assign grant_pipe = bus.pipe_valid & !grant_mc;

    assign bus.mc_ready = clr & !full;
    assign bus.stall    = clr & bus.pipe_valid & grant_mc;
    assign enq          = bus.mc_valid & bus.mc_ready;

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;

    // Next buffer bookkeeping: squash, dequeue, enqueue, starvation.
    always_comb begin
        valid_d  = valid_q;
        dead_d   = dead_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (grant_pipe && bus.pipe_reg != 5'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && reg_q[i] == bus.pipe_reg)
                    dead_d[i] = 1'b1;
            end
        end
        if (grant_mc) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            dead_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (enq && !grant_mc)
            count_d = count_q + CW'(1);
        else if (!enq && grant_mc)
            count_d = count_q - CW'(1);
        if (!nonempty || grant_mc)
            starve_d = '0;
        else if (bus.pipe_valid && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    // Next write-port value for whichever request won this cycle.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_mc) begin
            rf_we_d    = !head_dead && head_reg != 5'd0;
            rf_addr_d  = head_reg;
            rf_wdata_d = head_data;
        end else if (grant_pipe) begin
            rf_we_d    = bus.pipe_reg != 5'd0;
            rf_addr_d  = bus.pipe_reg;
            rf_wdata_d = bus.pipe_data;
        end
    end

    // Buffer control state; reset drops every buffered entry.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            valid_q  <= '0;
            dead_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            valid_q  <= valid_d;
            dead_q   <= dead_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Buffer payload storage, written at the tail on accept.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (enq) begin
            reg_q[wr_ptr_q]  <= bus.mc_reg;
            data_q[wr_ptr_q] <= bus.mc_data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed checks of the write-port arbiter: pipe/buffer grants,
// starvation, full buffer, WAW squash, register 0, and reset.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic clr = 1'b0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int bad_wr = 0;
    logic [31:0] rf_model [32];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pipe(input logic v, input logic [4:0] r,
                        input logic [31:0] d);
        bus.pipe_valid = v;
        bus.pipe_reg   = r;
        bus.pipe_data  = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
        bus.mc_valid = v;
        bus.mc_reg   = r;
        bus.mc_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] r,
                          input logic [31:0] d);
        chk({tag, "_we"},   32'(bus.rf_we), 32'd1);
        chk({tag, "_addr"}, 32'(bus.rf_addr), 32'(r));
        chk({tag, "_data"}, bus.rf_wdata, d);
    endtask

    // Mirror of the register file, plus a count of writes that reset
    // should have discarded (registers 25 and 26).
    always @(negedge clk) begin
        if (bus.rf_we) begin
            rf_model[bus.rf_addr] = bus.rf_wdata;
            if (bus.rf_addr == 5'd25 || bus.rf_addr == 5'd26)
                bad_wr++;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        pipe(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);

        #12;
        chk("rst_we",    32'(bus.rf_we), 32'd0);
        chk("rst_addr",  32'(bus.rf_addr), 32'd0);
        chk("rst_data",  bus.rf_wdata, 32'd0);
        chk("rst_ready", 32'(bus.mc_ready), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        clr = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.mc_ready), 32'd1);

        // Pipe only
        pipe(1'b1, 5'd5, 32'h1234);
        #1;
        chk("p_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("p", 5'd5, 32'h1234);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        chk("p_stall2", 32'(bus.stall), 32'd0);
        tick();
        chk("idle_we", 32'(bus.rf_we), 32'd0);

        // Multi-cycle only
        mc(1'b1, 5'd7, 32'hCAFE);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        chk("mc_nolat", 32'(bus.rf_we), 32'd0);
        tick();
        chk_wr("mc", 5'd7, 32'hCAFE);
        tick();
        chk("mc_idle", 32'(bus.rf_we), 32'd0);

        // Starvation
        pipe(1'b1, 5'd3, 32'h33);
        mc(1'b1, 5'd9, 32'h99);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        chk_wr("s0", 5'd3, 32'h33);
        pipe(1'b1, 5'd10, 32'hA0);
        #1;
        chk("s1_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("s1", 5'd10, 32'hA0);
        pipe(1'b1, 5'd11, 32'hB0);
        #1;
        chk("s2_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("s2", 5'd11, 32'hB0);
        pipe(1'b1, 5'd12, 32'hC0);
        #1;
        chk("s3_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("s3", 5'd12, 32'hC0);
        pipe(1'b1, 5'd13, 32'hD0);
        #1;
        chk("s4_stall", 32'(bus.stall), 32'd1);
        tick();
        chk_wr("s4", 5'd9, 32'h99);
        chk("s5_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("s5", 5'd13, 32'hD0);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("s_idle", 32'(bus.rf_we), 32'd0);

        // Full buffer
        pipe(1'b1, 5'd14, 32'hE0);
        mc(1'b1, 5'd20, 32'h2020);
        tick();
        pipe(1'b1, 5'd15, 32'hF0);
        mc(1'b1, 5'd21, 32'h2121);
        #1;
        chk("f1_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("f1", 5'd15, 32'hF0);
        pipe(1'b1, 5'd16, 32'h16);
        mc(1'b1, 5'd22, 32'h2222);
        #1;
        chk("f_ready0", 32'(bus.mc_ready), 32'd0);
        chk("f_stall", 32'(bus.stall), 32'd1);
        tick();
        chk_wr("f2", 5'd20, 32'h2020);
        chk("f_ready1", 32'(bus.mc_ready), 32'd1);
        chk("f2_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("f3", 5'd16, 32'h16);
        mc(1'b0, 5'd0, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        chk("f3_ready", 32'(bus.mc_ready), 32'd0);
        tick();
        chk_wr("f4", 5'd21, 32'h2121);
        tick();
        chk_wr("f5", 5'd22, 32'h2222);
        tick();
        chk("f_idle", 32'(bus.rf_we), 32'd0);

        // WAW squash
        mc(1'b1, 5'd4, 32'hAAAA);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd4, 32'hBBBB);
        #1;
        chk("w_stall", 32'(bus.stall), 32'd0);
        tick();
        chk_wr("w", 5'd4, 32'hBBBB);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("w_dead_we", 32'(bus.rf_we), 32'd0);
        tick();
        chk("w_rf4", rf_model[4], 32'hBBBB);

        // Register 0 write is consumed silently
        pipe(1'b1, 5'd0, 32'h5555);
        tick();
        chk("r0_we", 32'(bus.rf_we), 32'd0);

        // Reset mid-operation
        pipe(1'b1, 5'd18, 32'h18);
        mc(1'b1, 5'd25, 32'h25);
        tick();
        pipe(1'b1, 5'd19, 32'h19);
        mc(1'b1, 5'd26, 32'h26);
        tick();
        mc(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd27, 32'h27);
        chk_wr("x_pre", 5'd19, 32'h19);
        #1;
        chk("x_stall", 32'(bus.stall), 32'd1);
        clr = 1'b0;
        #1;
        chk("x_we", 32'(bus.rf_we), 32'd0);
        chk("x_stall0", 32'(bus.stall), 32'd0);
        chk("x_ready0", 32'(bus.mc_ready), 32'd0);
        clr = 1'b1;
        pipe(1'b1, 5'd28, 32'h28);
        tick();
        chk_wr("x_first", 5'd28, 32'h28);
        pipe(1'b0, 5'd0, 32'd0);
        repeat (5) tick();
        chk("x_lost", 32'(bad_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
